// File: rtl/uart_rx_cmd.sv
// rtl/uart_rx_cmd.sv - 8N1 UART receiver with 4-byte command-frame decoder
module uart_rx_cmd #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        rx_busy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [23:0] cmd_arg,
  output logic        cmd_err
);
  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC + 1);
  localparam int TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_t;
  typedef enum logic [1:0] {P_OP, P_A2, P_A1, P_A0} p_state_t;

  logic          sync1_q, sync2_q, rxd_s;
  rx_state_t     rx_state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, frame_err_q;

  p_state_t      p_state_q;
  logic [7:0]    op_q;
  logic [15:0]   arg_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    cmd_op_q;
  logic [23:0]   cmd_arg_q;
  logic          cmd_valid_q, cmd_err_q;
  logic          is_op;

  assign rxd_s   = sync2_q;
  assign cnt_d   = cnt_q + CW'(1);
  assign tcnt_d  = tcnt_q + TW'(1);
  assign shift_d = {rxd_s, shift_q[7:1]};
  assign is_op   = (rx_data_q == 8'h57) || (rx_data_q == 8'h52) || (rx_data_q == 8'h53);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // Byte receiver: mid-bit sampling, LSB first, BREAK swallows a held-low line.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (rx_state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            rx_state_q <= S_START;
            cnt_q      <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            rx_state_q <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) rx_state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxd_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              rx_state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_state_q  <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_BREAK: begin
          if (rxd_s) rx_state_q <= S_IDLE;
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // Frame parser: opcode then big-endian 24-bit argument; a new byte beats a timeout.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q   <= P_OP;
      op_q        <= '0;
      arg_q       <= '0;
      tcnt_q      <= '0;
      cmd_op_q    <= '0;
      cmd_arg_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      if (rx_valid_q) begin
        tcnt_q <= '0;
        unique case (p_state_q)
          P_OP: begin
            if (is_op) begin
              op_q      <= rx_data_q;
              p_state_q <= P_A2;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
          P_A2: begin
            arg_q[15:8] <= rx_data_q;
            p_state_q   <= P_A1;
          end
          P_A1: begin
            arg_q[7:0] <= rx_data_q;
            p_state_q  <= P_A0;
          end
          P_A0: begin
            cmd_op_q    <= op_q;
            cmd_arg_q   <= {arg_q, rx_data_q};
            cmd_valid_q <= 1'b1;
            p_state_q   <= P_OP;
          end
        endcase
      end else if (frame_err_q) begin
        tcnt_q <= '0;
        if (p_state_q != P_OP) begin
          cmd_err_q <= 1'b1;
          p_state_q <= P_OP;
        end
      end else if (p_state_q == P_OP) begin
        tcnt_q <= '0;
      end else if (tcnt_q == TO_LAST) begin
        cmd_err_q <= 1'b1;
        p_state_q <= P_OP;
        tcnt_q    <= '0;
      end else begin
        tcnt_q <= tcnt_d;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (rx_state_q != S_IDLE);
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_arg   = cmd_arg_q;
  assign cmd_err   = cmd_err_q;

endmodule
